mem_port_arbiter: RTL and testbench

- Shares the single address/data port of the 8-bit CPU memory (32K address space, negedge write, combinational read) between two requesters: port A (CPU bus adapter) and port B (loader/DMA engine).
- Two-way round-robin arbitration, a one-cycle command register stage and a registered read-data return.
- Accepts one access per cycle at full throughput.
- Sits between the requesters and the memory instance; drives the memory's ADDRESS, DATA_IN, write_enable and output_enable, and samples DATA_OUT.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr2.sv | 17 +
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: widths, owner encoding, command record.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 8;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  valid;
    owner_e                owner;
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker; the previous winner is held by the parent.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_e last_grant,
  output logic   gnt_a,
  output logic   gnt_b
);

  always_comb begin
    gnt_a = req_a & (~req_b | (last_grant == OWNER_B));
    gnt_b = req_b & (~req_a | (last_grant == OWNER_A));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between requesters A and B: round-robin grant, registered
// command stage, registered read return. Optional write protection: MEM_PORT_ARBITER_WRITE_PROTECT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W       = MEM_ADDR_W,
  parameter int                DATA_W       = MEM_DATA_W,
  parameter logic [ADDR_W-1:0] PROTECT_BASE = 15'h1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write_enable,
  output logic              mem_output_enable
);

`ifdef MEM_PORT_ARBITER_WRITE_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  owner_e      last_grant;
  logic        gnt_a, gnt_b;
  logic        grant_any;
  logic        protect_hit;
  mem_cmd_t    cmd_d;
  mem_cmd_t    cmd_p0;
  logic        rd_p0;
  logic        rvld_a_p1, rvld_b_p1;
  logic [DATA_W-1:0] rdata_a_p1, rdata_b_p1;

  mem_arb_rr2 u_rr2 (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b)
  );

  // ---- cycle N: arbitration and command select ----
  always_comb begin
    a_ack       = gnt_a & ~reset;
    b_ack       = gnt_b & ~reset;
    grant_any   = a_ack | b_ack;
    cmd_d.owner = gnt_b ? OWNER_B : OWNER_A;
    cmd_d.we    = gnt_b ? b_we    : a_we;
    cmd_d.addr  = gnt_b ? b_addr  : a_addr;
    cmd_d.wdata = gnt_b ? b_wdata : a_wdata;
    // A protected write is still acked but never reaches the memory.
    protect_hit = PROTECT_EN & cmd_d.we & (cmd_d.addr >= PROTECT_BASE);
    cmd_d.valid = grant_any & ~protect_hit;
  end

  always_ff @(posedge clk) begin
    cmd_p0 <= cmd_d;
    if (reset) begin
      cmd_p0.valid <= 1'b0;
      last_grant   <= OWNER_B;
    end else if (grant_any) begin
      last_grant   <= cmd_d.owner;
    end
  end

  // ---- cycle N+1: drive memory from the command register ----
  always_comb begin
    mem_address       = '0;
    mem_data_in       = '0;
    mem_write_enable  = 1'b0;
    mem_output_enable = 1'b0;
    if (cmd_p0.valid) begin
      mem_address       = cmd_p0.addr;
      mem_data_in       = cmd_p0.wdata;
      mem_write_enable  = cmd_p0.we & ~reset;
      mem_output_enable = ~cmd_p0.we;
    end
  end

  assign rd_p0 = cmd_p0.valid & ~cmd_p0.we;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvld_a_p1  <= 1'b0;
      rvld_b_p1  <= 1'b0;
      rdata_a_p1 <= '0;
      rdata_b_p1 <= '0;
    end else begin
      rvld_a_p1 <= rd_p0 & (cmd_p0.owner == OWNER_A);
      rvld_b_p1 <= rd_p0 & (cmd_p0.owner == OWNER_B);
      if (rd_p0 && (cmd_p0.owner == OWNER_A)) rdata_a_p1 <= mem_data_out;
      if (rd_p0 && (cmd_p0.owner == OWNER_B)) rdata_b_p1 <= mem_data_out;
    end
  end

  // ---- cycle N+2: read data return ----
  assign a_rvalid = rvld_a_p1;
  assign b_rvalid = rvld_b_p1;
  assign a_rdata  = rdata_a_p1;
  assign b_rdata  = rdata_b_p1;

`ifdef MEM_PORT_ARBITER_WRITE_PROTECT_EN
  logic err_a_p0, err_b_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_a_p0 <= 1'b0;
      err_b_p0 <= 1'b0;
    end else begin
      err_a_p0 <= grant_any & protect_hit & (cmd_d.owner == OWNER_A);
      err_b_p0 <= grant_any & protect_hit & (cmd_d.owner == OWNER_B);
    end
  end

  assign a_err = err_a_p0;
  assign b_err = err_b_p0;
`else
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand sequences, random traffic vs. event model.
module tb_mem_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
`ifdef MEM_PORT_ARBITER_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, a_ack, a_rvalid, a_err;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_ack, b_rvalid, b_err;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_write_enable, mem_output_enable;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem     [0:32767];
  logic [DW-1:0] ref_mem [0:32767];

  always #5 clk = ~clk;

  // Behavioural memory: negedge write, combinational read.
  always @(negedge clk) if (mem_write_enable) mem[mem_address] <= mem_data_in;
  assign mem_data_out = mem[mem_address];

  mem_port_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .a_req             (a_req),
    .a_we              (a_we),
    .a_addr            (a_addr),
    .a_wdata           (a_wdata),
    .a_ack             (a_ack),
    .a_rvalid          (a_rvalid),
    .a_rdata           (a_rdata),
    .a_err             (a_err),
    .b_req             (b_req),
    .b_we              (b_we),
    .b_addr            (b_addr),
    .b_wdata           (b_wdata),
    .b_ack             (b_ack),
    .b_rvalid          (b_rvalid),
    .b_rdata           (b_rdata),
    .b_err             (b_err),
    .mem_address       (mem_address),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out),
    .mem_write_enable  (mem_write_enable),
    .mem_output_enable (mem_output_enable)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit prot(input bit we, input logic [AW-1:0] addr);
    return WP && we && (addr >= 15'h1000);
  endfunction

  // Reference model: timestamped events (memory command, read return, error pulse).
  typedef struct {
    int            due;
    bit            rd;
    bit            owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           cmdq[$];
  ev_t           rvq[$];
  ev_t           errq[$];
  int            cyc = 0;
  bit            m_last = 1'b1;
  logic [DW-1:0] m_rdata [2];
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    bit ga, gb, ew, eo, rva, rvb, era, erb;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    ev_t e;
    ga = a_req && !reset && (!b_req || m_last);
    gb = b_req && !reset && (!a_req || !m_last);
    ew = 1'b0; eo = 1'b0; eaddr = '0; edin = '0;
    if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
      eaddr = cmdq[0].addr;
      edin  = cmdq[0].data;
      ew    = !cmdq[0].rd && !reset;
      eo    = cmdq[0].rd;
    end
    rva = rvq.size() > 0 && rvq[0].due == cyc && rvq[0].owner == 1'b0;
    rvb = rvq.size() > 0 && rvq[0].due == cyc && rvq[0].owner == 1'b1;
    era = errq.size() > 0 && errq[0].due == cyc && errq[0].owner == 1'b0;
    erb = errq.size() > 0 && errq[0].due == cyc && errq[0].owner == 1'b1;
    if (mon_en) begin
      chk("mon_a_ack", a_ack, ga);
      chk("mon_b_ack", b_ack, gb);
      chk("mon_a_rvalid", a_rvalid, rva);
      chk("mon_b_rvalid", b_rvalid, rvb);
      chk("mon_a_rdata", a_rdata, m_rdata[0]);
      chk("mon_b_rdata", b_rdata, m_rdata[1]);
      chk("mon_a_err", a_err, era);
      chk("mon_b_err", b_err, erb);
      chk("mon_we", mem_write_enable, ew);
      chk("mon_oe", mem_output_enable, eo);
      chk("mon_addr", mem_address, eaddr);
      chk("mon_din", mem_data_in, edin);
    end
    if (reset) begin
      cmdq.delete(); rvq.delete(); errq.delete();
      m_last = 1'b1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end else begin
      while (rvq.size() > 0 && rvq[0].due <= cyc) void'(rvq.pop_front());
      while (errq.size() > 0 && errq[0].due <= cyc) void'(errq.pop_front());
      while (cmdq.size() > 0 && cmdq[0].due <= cyc) begin
        e = cmdq.pop_front();
        if (e.rd) begin
          m_rdata[e.owner] = ref_mem[e.addr];
          e.due = cyc + 1;
          rvq.push_back(e);
        end else begin
          ref_mem[e.addr] = e.data;
        end
      end
      if (ga || gb) begin
        e.owner = gb;
        e.rd    = gb ? !b_we : !a_we;
        e.addr  = gb ? b_addr : a_addr;
        e.data  = gb ? b_wdata : a_wdata;
        e.due   = cyc + 1;
        m_last  = gb;
        if (prot(!e.rd, e.addr)) errq.push_back(e);
        else cmdq.push_back(e);
      end
    end
    cyc++;
  end

  typedef struct packed {
    logic          ra, wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          rb, wb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          ea, eb;
  } vec_t;

  task automatic drive(input logic ra, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic rb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 15'h1000 + AW'($urandom_range(0, 3));
      1:       return 15'h7FFF;
      default: return AW'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    bit acka, ackb;
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 32768; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[16] = 8'h11; ref_mem[16] = 8'h11;
    mem[32] = 8'h22; ref_mem[32] = 8'h22;

    // Contention: A reads 0x10, B reads 0x20, tie alternates A,B,A,B.
    for (int i = 0; i < 4; i++)
      vt.push_back('{1'b1, 1'b0, 15'h0010, 8'h00, 1'b1, 1'b0, 15'h0020, 8'h00, (i % 2) == 0, (i % 2) == 1});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});
    // Back-to-back B writes then reads of 0..7.
    for (int i = 0; i < 8; i++)
      vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b1, AW'(i), DW'(i), 1'b0, 1'b1});
    for (int i = 0; i < 8; i++)
      vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b0, AW'(i), 8'h00, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});
    // Single write then read, no contention.
    vt.push_back('{1'b1, 1'b1, 15'h0123, 8'h5A, 1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 15'h0123, 8'h00, 1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0});

    repeat (2) next_cycle();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_we", mem_write_enable, 0);
    chk("rst_mem_oe", mem_output_enable, 0);
    next_cycle();
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].ra, vt[i].wa, vt[i].aa, vt[i].da, vt[i].rb, vt[i].wb, vt[i].ab, vt[i].db);
      @(negedge clk);
      chk($sformatf("vec%0d_a_ack", i), a_ack, vt[i].ea);
      chk($sformatf("vec%0d_b_ack", i), b_ack, vt[i].eb);
      next_cycle();
    end
    chk("mem_0123", mem[15'h0123], 8'h5A);
    for (int i = 0; i < 8; i++) chk($sformatf("mem_%0d", i), mem[i], DW'(i));
    chk("hold_a_rdata", a_rdata, 8'h5A);
    chk("hold_b_rdata", b_rdata, 8'h07);

    // Reset right after an acked write: the write must be discarded.
    drive(1, 1, 15'h0040, 8'hFF, 0, 0, '0, '0);
    @(negedge clk);
    chk("rstmid_a_ack", a_ack, 1);
    next_cycle();
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rstmid_we", mem_write_enable, 0);
    next_cycle();
    reset = 1'b0;
    chk("rstmid_mem40", mem[15'h0040], 8'h00);
    drive(1, 0, 15'h0040, '0, 1, 0, 15'h0041, '0);
    @(negedge clk);
    chk("rstmid_a_rdata", a_rdata, 0);
    chk("rstmid_b_rdata", b_rdata, 0);
    chk("rstmid_a_rvalid", a_rvalid, 0);
    chk("rstmid_tie_a", a_ack, 1);
    chk("rstmid_tie_b", b_ack, 0);
    next_cycle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (3) next_cycle();

    // Write to the protected range.
    drive(1, 1, 15'h1FFC, 8'hAA, 0, 0, '0, '0);
    @(negedge clk);
    chk("wp_a_ack", a_ack, 1);
    next_cycle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("wp_a_err", a_err, WP);
    chk("wp_we", mem_write_enable, !WP);
    next_cycle();
    chk("wp_mem", mem[15'h1FFC], WP ? 8'h00 : 8'hAA);
    drive(1, 0, 15'h1FFC, '0, 0, 0, '0, '0);
    next_cycle();
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (3) next_cycle();
    chk("wp_a_rdata", a_rdata, WP ? 8'h00 : 8'hAA);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acka = a_ack;
      ackb = b_ack;
      next_cycle();
      reset = ($urandom_range(0, 49) == 0);
      if (!a_req || acka) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom_range(0, 1));
        a_addr = pick_addr();
        a_wdata = DW'($urandom);
      end
      if (!b_req || ackb) begin
        b_req = ($urandom_range(0, 3) != 0);
        b_we = 1'($urandom_range(0, 1));
        b_addr = pick_addr();
        b_wdata = DW'($urandom);
      end
    end
    reset = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (4) next_cycle();
    for (int i = 0; i < 16; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);
    chk("final_mem_7fff", mem[15'h7FFF], ref_mem[15'h7FFF]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
